// File: rtl/cpu_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        D_ACC  = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam int unsigned STARVE_MAX_DEF = 4;
    localparam int unsigned TIMEOUT_DEF    = 16;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_timeout.sv
// Watchdog for one memory transaction: flags expiry on the last allowed
// cycle without an acknowledge.
module arb_timeout
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ack,
    output logic expired
);

    localparam int unsigned CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q, active_d;

    // An ack in the limit cycle wins over expiry.
    assign expired = active_q && !ack && (cnt_q == LIMIT);

    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start) begin
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            if (ack || expired) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store,
// with anti-starvation for fetch and a per-transaction timeout.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err,
    output logic              stall_if,
    output logic              stall_d
);

    localparam int unsigned SW = cnt_width(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              err_q, err_d;

    logic in_acc;
    logic starved;
    logic d_win, if_win;
    logic to_start, to_expired;

    assign in_acc  = (state_q == IF_ACC) || (state_q == D_ACC);
    assign starved = if_req && (starve_q == STARVE_LIM);
    assign d_win   = d_req && !starved;
    assign if_win  = if_req && !d_win;

    arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .start   (to_start),
        .ack     (mem_ack),
        .expired (to_expired)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        starve_d   = starve_q;
        addr_d     = addr_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        err_d      = err_q;
        to_start   = 1'b0;
        unique case (state_q)
            IDLE: begin
                err_d = 1'b0;
                unique case (1'b1)
                    d_win: begin
                        state_d  = D_ACC;
                        owner_d  = OWN_D;
                        addr_d   = d_addr;
                        wen_d    = d_wen;
                        wdata_d  = d_wdata;
                        to_start = 1'b1;
                        if (if_req && (starve_q != STARVE_LIM)) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end
                    if_win: begin
                        state_d  = IF_ACC;
                        owner_d  = OWN_IF;
                        addr_d   = if_addr;
                        wen_d    = 1'b0;
                        wdata_d  = '0;
                        to_start = 1'b1;
                        starve_d = '0;
                    end
                    default: ;
                endcase
            end
            IF_ACC, D_ACC: begin
                if (mem_ack) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = mem_rdata;
                    end else begin
                        d_rdata_d = wen_q ? '0 : mem_rdata;
                    end
                end else if (to_expired) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = '0;
                    end else begin
                        d_rdata_d = '0;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            starve_q   <= '0;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            starve_q   <= starve_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            err_q      <= err_d;
        end
    end

    assign mem_req   = in_acc;
    assign mem_wen   = wen_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_valid = (state_q == RESP) && (owner_q == OWN_IF);
    assign d_valid  = (state_q == RESP) && (owner_q == OWN_D);
    assign err      = (state_q == RESP) && err_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

    assign stall_if = if_req && !if_valid;
    assign stall_d  = d_req && !d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run checked against a
// transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;
    localparam int TMO  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, d_req, d_wen, mem_ack;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic          if_valid, d_valid, mem_req, mem_wen, err;
    logic          stall_if, stall_d;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (SMAX),
        .TIMEOUT    (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_wen     (d_wen),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_valid   (d_valid),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .err       (err),
        .stall_if  (stall_if),
        .stall_d   (stall_d)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req    = 1'b0;
        d_req     = 1'b0;
        d_wen     = 1'b0;
        if_addr   = '0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        if_req    = 1'b1;
        d_req     = 1'b1;
        if_addr   = $urandom;
        d_addr    = $urandom;
        d_wen     = 1'b1;
        d_wdata   = $urandom;
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
        tick();
        total++;
        if ({mem_req, mem_wen, if_valid, d_valid, err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctl got=%b exp=00000",
                     {mem_req, mem_wen, if_valid, d_valid, err});
        end
        total++;
        if ({mem_addr, mem_wdata} !== 64'h0) begin
            bad++;
            $display("FAIL reset_bus got=%h exp=0", {mem_addr, mem_wdata});
        end
        total++;
        if ({if_rdata, d_rdata} !== 64'h0) begin
            bad++;
            $display("FAIL reset_rdata got=%h exp=0", {if_rdata, d_rdata});
        end
        tick();
        total++;
        if ({mem_req, if_valid, d_valid, err} !== 4'b0) begin
            bad++;
            $display("FAIL reset_hold got=%b exp=0000",
                     {mem_req, if_valid, d_valid, err});
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_lone_load();
        d_req   = 1'b1;
        d_wen   = 1'b0;
        d_addr  = 32'h100;
        d_wdata = $urandom;
        total++;
        if (mem_req !== 1'b0) begin
            bad++;
            $display("FAIL load_c0 mem_req got=%b exp=0", mem_req);
        end
        tick();
        total++;
        if ({mem_req, mem_wen, mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
            bad++;
            $display("FAIL load_c1 got=%b/%b/%h exp=1/0/100",
                     mem_req, mem_wen, mem_addr);
        end
        total++;
        if (stall_d !== 1'b1) begin
            bad++;
            $display("FAIL load_stall got=%b exp=1", stall_d);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        total++;
        if ({d_valid, if_valid, err, mem_req, stall_d} !== 5'b10000) begin
            bad++;
            $display("FAIL load_c2 got=%b exp=10000",
                     {d_valid, if_valid, err, mem_req, stall_d});
        end
        total++;
        if (d_rdata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL load_data got=%h exp=deadbeef", d_rdata);
        end
        d_req = 1'b0;
        tick();
        total++;
        if ({d_valid, mem_req, d_rdata} !== {2'b00, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL load_c3 got=%b%b/%h exp=00/deadbeef",
                     d_valid, mem_req, d_rdata);
        end
    endtask

    task automatic test_store();
        d_req     = 1'b1;
        d_wen     = 1'b1;
        d_addr    = 32'h200;
        d_wdata   = 32'h12345678;
        mem_rdata = 32'hA5A55A5A;
        tick();
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({mem_req, mem_wen, mem_addr, mem_wdata} !==
                {1'b1, 1'b1, 32'h200, 32'h12345678}) begin
                bad++;
                $display("FAIL store_bus k=%0d got=%b/%b/%h/%h exp=1/1/200/12345678",
                         k, mem_req, mem_wen, mem_addr, mem_wdata);
            end
            d_addr  = $urandom;
            d_wdata = $urandom;
            mem_ack = (k == 2);
            tick();
        end
        mem_ack = 1'b0;
        total++;
        if ({d_valid, err, d_rdata} !== {2'b10, 32'h0}) begin
            bad++;
            $display("FAIL store_resp got=%b%b/%h exp=10/0",
                     d_valid, err, d_rdata);
        end
        d_req = 1'b0;
        d_wen = 1'b0;
        tick();
        total++;
        if ({d_valid, mem_req} !== 2'b00) begin
            bad++;
            $display("FAIL store_idle got=%b exp=00", {d_valid, mem_req});
        end
    endtask

    task automatic test_contention();
        logic [9:0] order;
        logic       got_if;
        int         w;
        order = 10'b1000010000;
        do_reset();
        if_addr = 32'h1000;
        d_addr  = 32'h2000;
        d_wen   = 1'b0;
        if_req  = 1'b1;
        d_req   = 1'b1;
        for (int g = 0; g < 10; g++) begin
            w = 0;
            while (mem_req !== 1'b1 && w < 4) begin
                tick();
                w++;
            end
            total++;
            if (mem_req !== 1'b1) begin
                bad++;
                $display("FAIL contend_req g=%0d got=%b exp=1", g, mem_req);
                break;
            end
            got_if = (mem_addr === 32'h1000);
            total++;
            if (got_if !== order[g]) begin
                bad++;
                $display("FAIL contend_order g=%0d got_if=%b exp_if=%b",
                         g, got_if, order[g]);
            end
            mem_ack   = 1'b1;
            mem_rdata = 32'hC0DE0000 + g;
            tick();
            mem_ack = 1'b0;
            total++;
            if ({if_valid, d_valid} !== (order[g] ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL contend_valid g=%0d got=%b exp_if=%b",
                         g, {if_valid, d_valid}, order[g]);
            end
            tick();
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        if_req    = 1'b1;
        if_addr   = 32'h3000;
        mem_rdata = 32'hFFFF0000;
        tick();
        for (int k = 0; k < TMO; k++) begin
            total++;
            if ({mem_req, if_valid, err} !== 3'b100) begin
                bad++;
                $display("FAIL tmo_wait k=%0d got=%b exp=100",
                         k, {mem_req, if_valid, err});
            end
            tick();
        end
        total++;
        if ({if_valid, err, d_valid, if_rdata} !== {3'b110, 32'h0}) begin
            bad++;
            $display("FAIL tmo_resp got=%b/%h exp=110/0",
                     {if_valid, err, d_valid}, if_rdata);
        end
        if_req = 1'b0;
        tick();
        total++;
        if ({mem_req, err, if_valid} !== 3'b000) begin
            bad++;
            $display("FAIL tmo_idle got=%b exp=000", {mem_req, err, if_valid});
        end
    endtask

    task automatic test_ack_limit();
        d_req  = 1'b1;
        d_wen  = 1'b0;
        d_addr = 32'h400;
        tick();
        for (int k = 0; k < TMO; k++) begin
            total++;
            if ({mem_req, d_valid} !== 2'b10) begin
                bad++;
                $display("FAIL lim_wait k=%0d got=%b exp=10",
                         k, {mem_req, d_valid});
            end
            mem_ack   = (k == TMO - 1);
            mem_rdata = 32'h0BADF00D;
            tick();
        end
        mem_ack = 1'b0;
        total++;
        if ({d_valid, err, d_rdata} !== {2'b10, 32'h0BADF00D}) begin
            bad++;
            $display("FAIL lim_resp got=%b/%h exp=10/0badf00d",
                     {d_valid, err}, d_rdata);
        end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        d_req  = 1'b1;
        d_wen  = 1'b0;
        d_addr = 32'h500;
        tick();
        total++;
        if (mem_req !== 1'b1) begin
            bad++;
            $display("FAIL rmid_req got=%b exp=1", mem_req);
        end
        rst = 1'b1;
        tick();
        total++;
        if ({mem_req, d_valid, err} !== 3'b000) begin
            bad++;
            $display("FAIL rmid_abort got=%b exp=000", {mem_req, d_valid, err});
        end
        rst       = 1'b0;
        d_req     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h77778888;
        tick();
        mem_ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({mem_req, d_valid, if_valid, err, d_rdata} !== {4'b0, 32'h0}) begin
                bad++;
                $display("FAIL rmid_late k=%0d got=%b/%h exp=0000/0",
                         k, {mem_req, d_valid, if_valid, err}, d_rdata);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int            phase, nxt, nmem, delay, starve, r;
        bit            own_if, exp_err, if_pend, d_pend, ev_if, ev_d;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_wdata, last_if, last_d;
        bit            m_wen;
        do_reset();
        phase   = 0;
        starve  = 0;
        if_pend = 0;
        d_pend  = 0;
        last_if = '0;
        last_d  = '0;
        own_if  = 0;
        exp_err = 0;
        nmem    = 0;
        delay   = 0;
        m_addr  = '0;
        m_wdata = '0;
        m_wen   = 0;
        for (int c = 0; c < 3000; c++) begin
            ev_if = (phase == 2) && own_if;
            ev_d  = (phase == 2) && !own_if;
            total++;
            if ({if_valid, d_valid, err} !== {ev_if, ev_d, (phase == 2) && exp_err}) begin
                bad++;
                $display("FAIL rnd_valid c=%0d got=%b exp=%b", c,
                         {if_valid, d_valid, err}, {ev_if, ev_d, (phase == 2) && exp_err});
            end
            total++;
            if (mem_req !== (phase == 1)) begin
                bad++;
                $display("FAIL rnd_memreq c=%0d got=%b exp=%b", c, mem_req, phase == 1);
            end
            total++;
            if ({stall_if, stall_d} !== {if_req && !ev_if, d_req && !ev_d}) begin
                bad++;
                $display("FAIL rnd_stall c=%0d got=%b exp=%b", c,
                         {stall_if, stall_d}, {if_req && !ev_if, d_req && !ev_d});
            end
            total++;
            if ({if_rdata, d_rdata} !== {last_if, last_d}) begin
                bad++;
                $display("FAIL rnd_rdata c=%0d got=%h/%h exp=%h/%h",
                         c, if_rdata, d_rdata, last_if, last_d);
            end
            if (phase == 1) begin
                total++;
                if ({mem_addr, mem_wen} !== {m_addr, m_wen} ||
                    (m_wen && mem_wdata !== m_wdata)) begin
                    bad++;
                    $display("FAIL rnd_bus c=%0d got=%h/%b/%h exp=%h/%b/%h",
                             c, mem_addr, mem_wen, mem_wdata, m_addr, m_wen, m_wdata);
                end
            end
            nxt       = phase;
            mem_rdata = $urandom;
            mem_ack   = 1'b0;
            if (phase == 1) begin
                if (nmem == delay) begin
                    mem_ack = 1'b1;
                    exp_err = 0;
                    if (own_if) last_if = mem_rdata;
                    else last_d = m_wen ? '0 : mem_rdata;
                    nxt = 2;
                end else if (nmem == TMO - 1) begin
                    exp_err = 1;
                    if (own_if) last_if = '0;
                    else last_d = '0;
                    nxt = 2;
                end
                nmem++;
                if ($urandom_range(0, 3) == 0) begin
                    if (own_if) if_req = 1'b0;
                    else d_req = 1'b0;
                end
            end else begin
                // stray acks outside a transaction must be ignored
                mem_ack = ($urandom_range(0, 3) == 0);
                if (phase == 2) begin
                    if (own_if) begin
                        if_pend = 0;
                        if_req  = 1'b0;
                    end else begin
                        d_pend = 0;
                        d_req  = 1'b0;
                    end
                    nxt = 0;
                end
            end
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1;
                if_req  = 1'b1;
                if_addr = $urandom;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend  = 1;
                d_req   = 1'b1;
                d_wen   = $urandom_range(0, 1);
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            if (phase == 0 && (if_req || d_req)) begin
                own_if = if_req && (!d_req || starve == SMAX);
                if (own_if) begin
                    starve = 0;
                    m_addr = if_addr;
                    m_wen  = 0;
                end else begin
                    if (if_req && starve < SMAX) starve++;
                    m_addr  = d_addr;
                    m_wen   = d_wen;
                    m_wdata = d_wdata;
                end
                r = $urandom_range(0, 9);
                if (r < 6) delay = $urandom_range(0, 3);
                else if (r < 8) delay = TMO - 1;
                else delay = TMO + 3;
                nmem = 0;
                nxt  = 1;
            end
            phase = nxt;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_lone_load();
        test_store();
        test_contention();
        test_timeout();
        test_ack_limit();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
